// File: rtl/imm_buf.sv
// imm_buf: row-allocated immediate buffer, NWAY slots per row, NREAD tag-addressed read ports.
// Optional same-cycle write-to-read bypass when IMM_BYPASS_EN is defined.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_alloc, i_wdata  allocate the lowest free row and fill its NWAY slots
//   o_alloc_row       row an alloc would be granted this cycle (0 when full)
//   o_full, o_count   occupancy status, from registered state only
//   i_free            bitmap of rows to release at the next edge
//   i_raddr           NREAD tags {row, slot}
//   o_rdata, o_rvalid per-port read data and occupancy of the addressed row
module imm_buf #(
    parameter int ROWS  = 8,
    parameter int NWAY  = 4,
    parameter int WIDTH = 32,
    parameter int NREAD = 4,
    localparam int RW = $clog2(ROWS),
    localparam int SW = $clog2(NWAY),
    localparam int AW = RW + SW
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_alloc,
    input  logic [NWAY*WIDTH-1:0]  i_wdata,
    output logic [RW-1:0]          o_alloc_row,
    output logic                   o_full,
    output logic [RW:0]            o_count,
    input  logic [ROWS-1:0]        i_free,
    input  logic [NREAD*AW-1:0]    i_raddr,
    output logic [NREAD*WIDTH-1:0] o_rdata,
    output logic [NREAD-1:0]       o_rvalid
);

    logic [ROWS-1:0]  valid;
    logic [ROWS-1:0]  valid_next;
    logic [RW:0]      count;
    logic [RW:0]      count_next;
    logic [RW:0]      free_cnt;
    logic [ROWS-1:0]  free_hit;
    logic [RW-1:0]    alloc_row;
    logic             full;
    logic             acc;
    logic [WIDTH-1:0] wslot [NWAY];
    logic [WIDTH-1:0] data  [ROWS][NWAY];

    always_comb begin
        for (int k = 0; k < NWAY; k++) begin
            wslot[k] = i_wdata[k*WIDTH +: WIDTH];
        end
    end

    // Scan downward so the lowest free row wins; all-valid leaves 0.
    always_comb begin
        alloc_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_row = RW'(i);
            end
        end
    end

    assign full = (count == (RW+1)'(ROWS));
    assign acc  = i_alloc & ~full;

    assign free_hit = i_free & valid;

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < ROWS; i++) begin
            free_cnt = free_cnt + (RW+1)'(free_hit[i]);
        end
    end

    // The allocated row is currently invalid, so it never collides
    // with a row being freed in the same cycle.
    always_comb begin
        valid_next = valid & ~free_hit;
        count_next = count - free_cnt;
        if (acc) begin
            valid_next[alloc_row] = 1'b1;
            count_next            = count_next + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid <= '0;
            count <= '0;
        end else begin
            valid <= valid_next;
            count <= count_next;
        end
    end

    // Payload storage carries no reset; valid gates every read.
    always_ff @(posedge i_clk) begin
        if (acc) begin
            for (int k = 0; k < NWAY; k++) begin
                data[alloc_row][k] <= wslot[k];
            end
        end
    end

    assign o_alloc_row = alloc_row;
    assign o_full      = full;
    assign o_count     = count;

`ifdef IMM_BYPASS_EN
    // Reset gating keeps bypassed reads quiet while reset is held.
    logic byp;
    assign byp = acc & i_rst_n;
`endif

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [RW-1:0]    row;
        logic [SW-1:0]    slot;
        logic             in_rng;
        logic [WIDTH-1:0] rd;
        logic             rv;

        assign row  = i_raddr[p*AW+SW +: RW];
        assign slot = i_raddr[p*AW +: SW];

        assign in_rng = ({1'b0, row} < (RW+1)'(ROWS))
                     && ({1'b0, slot} < (SW+1)'(NWAY));

        always_comb begin
            rd = '0;
            rv = 1'b0;
            if (in_rng && valid[row]) begin
                rv = 1'b1;
                rd = data[row][slot];
            end
`ifdef IMM_BYPASS_EN
            if (in_rng && byp && (row == alloc_row)) begin
                rv = 1'b1;
                rd = wslot[slot];
            end
`endif
        end

        assign o_rdata[p*WIDTH +: WIDTH] = rd;
        assign o_rvalid[p]               = rv;
    end

endmodule

// File: tb/tb_imm_buf.sv
// tb_imm_buf: directed scenarios plus random traffic for imm_buf,
// checked against a row/slot array model of the buffer.
module tb_imm_buf;

    logic         clk;
    logic         rst_n;
    logic         alloc;
    logic [127:0] wdata;
    logic [7:0]   free;
    logic [19:0]  raddr;
    logic [2:0]   arow;
    logic         full;
    logic [3:0]   count;
    logic [127:0] rdata;
    logic [3:0]   rvalid;

    int vectors;
    int errs;

    bit        mvalid [8];
    bit [31:0] mdata  [8][4];

    imm_buf #(.ROWS(8), .NWAY(4), .WIDTH(32), .NREAD(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_alloc     (alloc),
        .i_wdata     (wdata),
        .o_alloc_row (arow),
        .o_full      (full),
        .o_count     (count),
        .i_free      (free),
        .i_raddr     (raddr),
        .o_rdata     (rdata),
        .o_rvalid    (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < 8; r++) c += mvalid[r];
        return c;
    endfunction

    function automatic int m_row();
        for (int r = 0; r < 8; r++) if (!mvalid[r]) return r;
        return 0;
    endfunction

    task automatic check_all();
        int        c;
        int        er;
        bit        acc;
        int        r;
        int        s;
        bit        ev;
        bit [31:0] ed;
        c   = m_count();
        er  = m_row();
        acc = alloc && (c < 8) && rst_n;
        chk("alloc_row", arow, er);
        chk("count", count, c);
        chk("full", full, c == 8);
        for (int p = 0; p < 4; p++) begin
            r  = int'(raddr[p*5+2 +: 3]);
            s  = int'(raddr[p*5 +: 2]);
            ev = mvalid[r];
            ed = ev ? mdata[r][s] : 32'h0;
`ifdef IMM_BYPASS_EN
            if (acc && r == er) begin
                ev = 1'b1;
                ed = wdata[s*32 +: 32];
            end
`endif
            chk($sformatf("rvalid%0d", p), rvalid[p], ev);
            chk($sformatf("rdata%0d", p), rdata[p*32 +: 32], ed);
        end
    endtask

    task automatic drive(input bit a, input logic [127:0] wd,
                         input logic [7:0] fr, input logic [19:0] ra);
        @(negedge clk);
        alloc = a;
        wdata = wd;
        free  = fr;
        raddr = ra;
        #1;
        check_all();
    endtask

    task automatic tick();
        bit acc;
        int er;
        acc = alloc && (m_count() < 8);
        er  = m_row();
        @(posedge clk);
        for (int r = 0; r < 8; r++) if (free[r]) mvalid[r] = 1'b0;
        if (acc) begin
            mvalid[er] = 1'b1;
            for (int k = 0; k < 4; k++) mdata[er][k] = wdata[k*32 +: 32];
        end
    endtask

    task automatic step(input bit a, input logic [127:0] wd,
                        input logic [7:0] fr, input logic [19:0] ra);
        drive(a, wd, fr, ra);
        tick();
    endtask

    function automatic logic [19:0] tags(input int t0, input int t1,
                                         input int t2, input int t3);
        return {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
    endfunction

    function automatic logic [127:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        vectors = 0;
        errs    = 0;
        for (int r = 0; r < 8; r++) mvalid[r] = 1'b0;
        rst_n = 1'b0;
        alloc = 1'b0;
        wdata = '0;
        free  = '0;
        raddr = tags(0, 1, 2, 3);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: first alloc lands in row 0
        drive(1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, 8'h00, tags(0, 1, 2, 3));
        chk("s1_row_pre", arow, 3'd0);
        tick();
        drive(1'b0, '0, 8'h00, tags(0, 1, 2, 3));
        chk("s1_tag0", rdata[31:0], 32'd1);
        chk("s1_tag3", rdata[127:96], 32'd4);
        chk("s1_rvalid", rvalid, 4'hf);
        chk("s1_count", count, 4'd1);
        tick();

        // Scenario 2: fill to full, then an ignored alloc
        for (int i = 1; i < 8; i++) step(1'b1, rnd_w(), 8'h00, tags(0, 4, 8, 28));
        drive(1'b1, {4{32'hFFFF_FFFF}}, 8'h00, tags(0, 1, 2, 3));
        chk("s2_full", full, 1'b1);
        chk("s2_count", count, 4'd8);
        tick();
        drive(1'b0, '0, 8'h00, tags(0, 1, 2, 3));
        chk("s2_tag0", rdata[31:0], 32'd1);
        chk("s2_count_hold", count, 4'd8);
        tick();

        // Scenario 3: free row 3 out of a full buffer
        step(1'b0, '0, 8'h08, tags(12, 13, 0, 31));
        drive(1'b0, '0, 8'h00, tags(12, 13, 0, 31));
        chk("s3_full", full, 1'b0);
        chk("s3_count", count, 4'd7);
        chk("s3_row", arow, 3'd3);
        chk("s3_rd12", rdata[31:0], 32'd0);
        chk("s3_rv12", rvalid[0], 1'b0);
        tick();

        // Scenario 4: alloc and free in the same cycle
        step(1'b0, '0, 8'hFF, tags(0, 4, 8, 12));
        step(1'b1, rnd_w(), 8'h00, tags(0, 4, 8, 12));
        step(1'b1, rnd_w(), 8'h00, tags(0, 4, 8, 12));
        drive(1'b1, rnd_w(), 8'h01, tags(0, 4, 8, 12));
        chk("s4_row_pre", arow, 3'd2);
        tick();
        drive(1'b0, '0, 8'h00, tags(0, 4, 8, 12));
        chk("s4_count", count, 4'd2);
        chk("s4_row_post", arow, 3'd0);
        chk("s4_rv", rvalid[2:0], 3'b110);
        tick();

        // Scenario 5: read a slot in the cycle it is written
        step(1'b0, '0, 8'hFF, tags(2, 0, 1, 3));
        drive(1'b1, {32'h0, 32'h0000DEAD, 32'h0, 32'h0}, 8'h00, tags(2, 0, 1, 3));
`ifdef IMM_BYPASS_EN
        chk("s5_byp_rd", rdata[31:0], 32'h0000DEAD);
        chk("s5_byp_rv", rvalid[0], 1'b1);
`else
        chk("s5_nobyp_rd", rdata[31:0], 32'h0);
        chk("s5_nobyp_rv", rvalid[0], 1'b0);
`endif
        tick();
        drive(1'b0, '0, 8'h00, tags(2, 0, 1, 3));
        chk("s5_next_rd", rdata[31:0], 32'h0000DEAD);
        chk("s5_next_rv", rvalid[0], 1'b1);
        tick();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 2) != 0, rnd_w(),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                 20'($urandom));
        end

        // Scenario 6: asynchronous reset between edges with 5 rows used
        step(1'b0, '0, 8'hFF, tags(0, 4, 8, 12));
        for (int i = 0; i < 5; i++) step(1'b1, rnd_w(), 8'h00, tags(0, 4, 8, 12));
        drive(1'b0, '0, 8'h00, tags(0, 4, 8, 12));
        chk("s6_count_pre", count, 4'd5);
        #2;
        rst_n = 1'b0;
        for (int r = 0; r < 8; r++) mvalid[r] = 1'b0;
        #1;
        chk("s6_count", count, 4'd0);
        chk("s6_full", full, 1'b0);
        chk("s6_rvalid", rvalid, 4'h0);
        chk("s6_row", arow, 3'd0);
        chk("s6_rdata", rdata, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, rnd_w(), 8'h00, tags(0, 1, 2, 3));
        drive(1'b0, '0, 8'h00, tags(0, 1, 2, 3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
